data_memory_copy_engine: RTL
============================

// Module: data_memory_copy_engine
// PURPOSE
//  Bus initiator for the 8-bit data memory port (address/read/write/data_inputs -> data_outputs).
//  Copies a block of LENGTH bytes from SRC to DST, one byte at a time: read, capture, write.
//  Sits beside the CPU datapath and owns the memory port while busy.
//  Reports completion with a one-cycle done pulse and an 8-bit additive checksum of the copied bytes.
// PARAMETERS
//  ADDR_WIDTH  8  memory address width; all address arithmetic is modulo 2**ADDR_WIDTH
//  DATA_WIDTH  8  memory data width and checksum width
//  LEN_WIDTH   8  width of the length field; max block = 2**LEN_WIDTH-1 bytes
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           asynchronous, active-low reset (0 = in reset)
//  start       in   1           launch a copy; sampled only in IDLE
//  abort       in   1           cancel an active copy
//  src_addr    in   ADDR_WIDTH  first source byte address, latched on accepted start
//  dst_addr    in   ADDR_WIDTH  first destination byte address, latched on accepted start
//  length      in   LEN_WIDTH   byte count, latched on accepted start
//  busy        out  1           1 from the cycle after accepted start until DONE or abort
//  done        out  1           1-cycle pulse on normal completion
//  checksum    out  DATA_WIDTH  running sum mod 2**DATA_WIDTH of bytes written; held after done
//  mem_address out  ADDR_WIDTH  memory address (registered)
//  mem_read    out  1           memory read strobe (registered)
//  mem_write   out  1           memory write strobe (registered)
//  mem_wdata   out  DATA_WIDTH  memory write data (registered)
//  mem_rdata   in   DATA_WIDTH  memory read data; valid the cycle after the edge that sampled mem_read=1
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; busy, done, mem_read, mem_write = 0; mem_address, mem_wdata, checksum = 0.
//  States: IDLE, RD, WAIT, WR, DONE. All outputs registered; no combinational path input->output.
//  IDLE: start=1 at edge -> latch src/dst/length, clear checksum, pick direction, busy=1.
//    length=0 -> DONE (no memory access); else RD with first read address.
//  Direction: descending iff dst>src and (dst-src)<length (9-bit unsigned compare, no wrap);
//    descending starts at src+length-1 / dst+length-1 and decrements; else ascending, increments.
//  RD   (1 cycle): mem_read=1, mem_address=current src, mem_write=0.
//  WAIT (1 cycle): mem_read=0; memory output settles.
//  WR   (1 cycle): mem_wdata=mem_rdata captured at WAIT->WR edge, mem_address=current dst, mem_write=1;
//    checksum += captured byte on the same edge. Remaining count decrements at WR exit.
//  WR exit: remaining>0 -> RD with next addresses; remaining=0 -> DONE.
//  DONE (1 cycle): done=1, busy=0, strobes 0 -> IDLE.
//  Timing: start accepted at edge E0; byte k read sampled at E0+3k+1, written at E0+3k+3;
//    done high in the cycle after edge E0+3N (N=length); length=0 -> done in cycle after E0+1.
//  mem_read and mem_write never high in the same cycle; each strobe high exactly 1 cycle per byte.
//  Address wrap: src/dst step modulo 2**ADDR_WIDTH (0xFF+1 -> 0x00, 0x00-1 -> 0xFF).
//  start while not IDLE: ignored, latched fields unchanged.
//  abort=1 at an edge in RD/WAIT/WR: -> IDLE, strobes 0, busy 0, no done pulse; checksum holds.
//    A write driven in the WR cycle is committed by the memory on that same edge (abort cannot cancel it).
//  abort in IDLE or DONE: no effect; start and abort both high in IDLE: start wins.
//  Reset mid-copy: immediate return to reset values; partially copied bytes remain in memory.
// TESTING (memory model: 32 entries on address[4:0], init mem[i]=i, mem[16+i]=-i; 1-cycle read latency)
//  1. Reset low then high, no start -> busy=0, done=0, mem_read=0, mem_write=0, checksum=0.
//  2. start src=0x00 dst=0x14 len=4 -> mem[20..23]=0,1,2,3; checksum=0x06; done 12 cycles after E0.
//  3. start src=0x00 dst=0x02 len=4 (overlap) -> descending; mem[2..5]=0,1,2,3; checksum=0x06.
//  4. start len=0 -> no mem_read/mem_write; done pulse in cycle after E0+1; checksum=0.
//  5. start src=0x10 dst=0x00 len=8, abort during 2nd WR -> mem[0]=0x00, mem[1]=0xFF, mem[2..7] unchanged; no done.
//  6. start pulsed again while busy; then reset=0 mid-RD -> 2nd start ignored; all outputs 0 immediately on reset.

Source files
------------

// File: rtl/data_memory_copy_engine.sv
// Byte-wide block copy engine: owns the data memory port while busy and moves LENGTH bytes
// from SRC to DST with a read / settle / write cadence, summing the bytes it writes.
module data_memory_copy_engine #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Wide enough to hold dst-src without wrap and to compare against the length field.
  localparam int unsigned CmpWidth = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;

  typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  desc_q, desc_d;
  logic                  busy_q, busy_d, done_q, done_d, rd_q, rd_d, wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, cksum_q, cksum_d;

  logic [CmpWidth-1:0]   gap, len_ext;
  logic                  start_desc;
  logic [ADDR_WIDTH-1:0] len_addr, first_src, first_dst, next_src, next_dst;

  // Direction choice and address stepping for the launch and per-byte advance.
  always_comb begin
    gap        = CmpWidth'(dst_addr) - CmpWidth'(src_addr);
    len_ext    = CmpWidth'(length);
    // Copy backwards only when the destination overlaps the tail of the source.
    start_desc = (dst_addr > src_addr) && (gap < len_ext);
    len_addr   = ADDR_WIDTH'(length);
    first_src  = start_desc ? (src_addr + len_addr - ADDR_WIDTH'(1)) : src_addr;
    first_dst  = start_desc ? (dst_addr + len_addr - ADDR_WIDTH'(1)) : dst_addr;
    next_src   = desc_q ? (src_q - ADDR_WIDTH'(1)) : (src_q + ADDR_WIDTH'(1));
    next_dst   = desc_q ? (dst_q - ADDR_WIDTH'(1)) : (dst_q + ADDR_WIDTH'(1));
  end

  // Next-state and next registered outputs; strobes and done default low every cycle.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    desc_d   = desc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    wdata_d  = wdata_q;
    cksum_d  = cksum_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d    = first_src;
          dst_d    = first_dst;
          remain_d = length;
          desc_d   = start_desc;
          cksum_d  = '0;
          busy_d   = 1'b1;
          if (length == '0) begin
            // Zero-length: dwell one busy cycle in WAIT with no access, then finish.
            state_d = StWait;
          end else begin
            state_d = StRd;
            rd_d    = 1'b1;
            addr_d  = first_src;
          end
        end
      end
      StRd: begin
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (remain_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = StWr;
          wr_d    = 1'b1;
          addr_d  = dst_q;
          wdata_d = mem_rdata;
          cksum_d = cksum_q + mem_rdata;
        end
      end
      StWr: begin
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = StRd;
            rd_d    = 1'b1;
            src_d   = next_src;
            dst_d   = next_dst;
            addr_d  = next_src;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      desc_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      cksum_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      desc_q   <= desc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      cksum_q  <= cksum_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign checksum    = cksum_q;
  assign mem_address = addr_q;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_wdata   = wdata_q;

endmodule
